// File: rtl/npu_cube_acc_seq.sv
// Carry-propagate resolve plus K-beat accumulator with start/abort/handshake control for one cube output lane.
// Build option: define NPU_CUBE_ACC_SAT_EN to clamp the accumulator at full scale on overflow instead of wrapping.
//
// state | meaning
// IDLE  | waiting for cfg_start; out_data holds the last result
// ACC   | accepting carry/sum beats until klen beats have been taken
// DRAIN | last beat still in flight through the resolve stage
// OUT   | result presented, waiting for out_ready
module npu_cube_acc_seq #(
    parameter int DWCS   = 19,
    parameter int DWACC  = 32,
    parameter int KCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_start,
    input  logic [KCNT_W-1:0] cfg_klen,
    input  logic              cfg_abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWCS-1:0]   in_cay,
    input  logic [DWCS-1:0]   in_sum,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWACC-1:0]  out_data,
    output logic              busy,
    output logic              done,
    output logic              ovf
);

    typedef enum logic [1:0] {IDLE, ACC, DRAIN, OUT} state_t;

    state_t              state_q, state_d;
    logic [KCNT_W-1:0]   klen_q, klen_d;
    logic [KCNT_W-1:0]   cnt_q, cnt_d;
    logic [DWCS+1:0]     s1_val_q, s1_val_d;
    logic                s1_vld_q, s1_vld_d;
    logic [DWACC-1:0]    acc_q, acc_d;
    logic                ovf_q, ovf_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic [DWACC-1:0]    out_data_q, out_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                accept;
    logic [KCNT_W:0]     cnt_inc;
    logic                last_beat;
    logic [DWACC:0]      acc_sum;

    always_comb begin
        state_d     = state_q;
        klen_d      = klen_q;
        cnt_d       = cnt_q;
        s1_val_d    = s1_val_q;
        s1_vld_d    = 1'b0;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;

        accept    = in_valid & in_ready_q;
        cnt_inc   = {1'b0, cnt_q} + (KCNT_W+1)'(1);
        last_beat = (cnt_inc == {1'b0, klen_q});
        acc_sum   = {1'b0, acc_q} + (DWACC+1)'(s1_val_q);

        if (accept) begin
            s1_val_d = (DWCS+2)'(in_sum) + ((DWCS+2)'(in_cay) << 1);
            s1_vld_d = 1'b1;
        end

        if (s1_vld_q) begin
`ifdef NPU_CUBE_ACC_SAT_EN
            acc_d = acc_sum[DWACC] ? {DWACC{1'b1}} : acc_sum[DWACC-1:0];
`else
            acc_d = acc_sum[DWACC-1:0];
`endif
            if (acc_sum[DWACC]) begin
                ovf_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (cfg_start && !cfg_abort) begin
                    klen_d = cfg_klen;
                    cnt_d  = '0;
                    acc_d  = '0;
                    ovf_d  = 1'b0;
                    if (cfg_klen != '0) begin
                        state_d    = ACC;
                        in_ready_d = 1'b1;
                    end else begin
                        state_d     = OUT;
                        out_valid_d = 1'b1;
                        out_data_d  = '0;
                    end
                end
            end
            ACC: begin
                // cnt ends at klen, so it never needs more than KCNT_W bits
                if (accept) begin
                    cnt_d = cnt_inc[KCNT_W-1:0];
                    if (last_beat) begin
                        in_ready_d = 1'b0;
                        state_d    = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Leave once the final resolved beat has landed in acc
                if (!s1_vld_q) begin
                    state_d     = OUT;
                    out_valid_d = 1'b1;
                    out_data_d  = acc_q;
                end
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    done_d      = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (cfg_abort) begin
            state_d     = IDLE;
            s1_vld_d    = 1'b0;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b0;
            done_d      = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            klen_q      <= '0;
            cnt_q       <= '0;
            s1_val_q    <= '0;
            s1_vld_q    <= 1'b0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            klen_q      <= klen_d;
            cnt_q       <= cnt_d;
            s1_val_q    <= s1_val_d;
            s1_vld_q    <= s1_vld_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_npu_cube_acc_seq.sv
// Directed bench for npu_cube_acc_seq: a 32-bit lane and a 21-bit lane share stimulus so overflow/saturation is visible.
module tb_npu_cube_acc_seq;

    localparam int DWCS   = 19;
    localparam int KCNT_W = 8;
`ifdef NPU_CUBE_ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cfg_start, cfg_abort, in_valid, out_ready;
    logic [KCNT_W-1:0] cfg_klen;
    logic [DWCS-1:0]   in_cay, in_sum;
    logic              in_ready, out_valid, busy, done, ovf;
    logic [31:0]       out_data;
    logic              in_ready_n, out_valid_n, busy_n, done_n, ovf_n;
    logic [20:0]       out_data_n;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    typedef struct packed {
        int               klen;
        bit               gap;
        logic [3:0][18:0] cay;
        logic [3:0][18:0] sum;
        logic [31:0]      exp_w;
        logic             ovf_w;
        logic [20:0]      exp_n;
        logic             ovf_n;
    } vec_t;

    vec_t vecs[3];
    vec_t v_after_abort;

    npu_cube_acc_seq #(.DWCS(DWCS), .DWACC(32), .KCNT_W(KCNT_W)) u_dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_klen(cfg_klen),
        .cfg_abort(cfg_abort), .in_valid(in_valid), .in_ready(in_ready),
        .in_cay(in_cay), .in_sum(in_sum), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy), .done(done), .ovf(ovf)
    );

    npu_cube_acc_seq #(.DWCS(DWCS), .DWACC(21), .KCNT_W(KCNT_W)) u_dut_n (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_klen(cfg_klen),
        .cfg_abort(cfg_abort), .in_valid(in_valid), .in_ready(in_ready_n),
        .in_cay(in_cay), .in_sum(in_sum), .out_valid(out_valid_n), .out_ready(out_ready),
        .out_data(out_data_n), .busy(busy_n), .done(done_n), .ovf(ovf_n)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input int k, input bit g,
                                input logic [18:0] c0, s0, c1, s1, c2, s2, c3, s3,
                                input logic [31:0] ew, input logic ow,
                                input logic [20:0] en, input logic on);
        vec_t v;
        v.klen = k;   v.gap = g;
        v.cay[0] = c0; v.sum[0] = s0; v.cay[1] = c1; v.sum[1] = s1;
        v.cay[2] = c2; v.sum[2] = s2; v.cay[3] = c3; v.sum[3] = s3;
        v.exp_w = ew; v.ovf_w = ow; v.exp_n = en; v.ovf_n = on;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic feed(input logic [18:0] c, input logic [18:0] s);
        int w;
        w = 0;
        in_valid = 1'b1; in_cay = c; in_sum = s;
        while (!in_ready && w < 20) begin tick(); w++; end
        if (w >= 20) begin
            n_chk++;
            $display("FAIL beat_accept: in_ready=%0b after %0d cycles, expected 1", in_ready, w);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag, output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin tick(); lat++; end
        if (!out_valid) begin
            n_chk++;
            $display("FAIL %s_out_timeout: out_valid=%0b, expected 1", tag, out_valid);
        end
    endtask

    task automatic finish_handshake(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_done"}, done, 1);
        chk({tag, "_valid_drop"}, out_valid, 0);
        tick();
        chk({tag, "_done_one_cycle"}, done, 0);
        chk({tag, "_busy_idle"}, busy, 0);
    endtask

    task automatic run_job(input vec_t v, input string tag);
        int lat;
        out_ready = 1'b0;
        cfg_klen  = v.klen[KCNT_W-1:0];
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int b = 0; b < v.klen; b++) begin
            if (v.gap && b > 0) tick();
            feed(v.cay[b], v.sum[b]);
        end
        chk({tag, "_in_ready_drop"}, in_ready, 0);
        wait_out(tag, lat);
        chk({tag, "_latency"}, lat, 2);
        chk({tag, "_data"}, out_data, v.exp_w);
        chk({tag, "_ovf"}, ovf, v.ovf_w);
        chk({tag, "_data_narrow"}, out_data_n, v.exp_n);
        chk({tag, "_ovf_narrow"}, ovf_n, v.ovf_n);
        finish_handshake(tag);
    endtask

    initial begin
        int  lat;
        bit  stable;
        bit  seen;

        vecs[0] = mk(3, 0, 19'd1, 19'd1, 19'd2, 19'd0, 19'd0, 19'd5, 19'd0, 19'd0,
                     32'd12, 1'b0, 21'd12, 1'b0);
        vecs[1] = mk(4, 1, 19'h7FFFF, 19'h7FFFF, 19'h7FFFF, 19'h7FFFF,
                     19'h7FFFF, 19'h7FFFF, 19'h7FFFF, 19'h7FFFF,
                     32'h5FFFF4, 1'b0, SAT ? 21'h1FFFFF : 21'h1FFFF4, 1'b1);
        vecs[2] = mk(2, 0, 19'h7FFFF, 19'h7FFFF, 19'h7FFFF, 19'h7FFFF, 19'd0, 19'd0, 19'd0, 19'd0,
                     32'h2FFFFA, 1'b0, SAT ? 21'h1FFFFF : 21'h0FFFFA, 1'b1);
        v_after_abort = mk(1, 0, 19'd0, 19'd7, 19'd0, 19'd0, 19'd0, 19'd0, 19'd0, 19'd0,
                           32'd7, 1'b0, 21'd7, 1'b0);

        rst_n = 1'b0; cfg_start = 0; cfg_abort = 0; cfg_klen = '0;
        in_valid = 0; in_cay = '0; in_sum = '0; out_ready = 0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", ovf, 0);

        for (int i = 0; i < 3; i++) run_job(vecs[i], $sformatf("vec%0d", i));

        // klen = 0: straight to OUT, result held while out_ready is low
        cfg_klen = '0; cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        chk("k0_valid", out_valid, 1);
        chk("k0_data", out_data, 0);
        chk("k0_in_ready", in_ready, 0);
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (!out_valid || out_data != 0 || in_ready || done) stable = 1'b0;
        end
        chk("k0_hold_stable", stable, 1);
        finish_handshake("k0");

        // abort after two of five beats
        cfg_klen = 8'd5; cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        feed(19'd1, 19'd1);
        feed(19'd1, 19'd1);
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid || done || busy) seen = 1'b1;
        end
        chk("abort_quiet", seen, 0);
        run_job(v_after_abort, "post_abort");

        // start and abort together in IDLE
        cfg_klen = 8'd2; cfg_start = 1'b1; cfg_abort = 1'b1;
        tick();
        cfg_start = 1'b0; cfg_abort = 1'b0;
        chk("start_abort_idle", busy, 0);

        // maximum job length
        cfg_klen = 8'd255; cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int b = 0; b < 255; b++) feed(19'd0, 19'd1);
        chk("kmax_in_ready_drop", in_ready, 0);
        wait_out("kmax", lat);
        chk("kmax_latency", lat, 2);
        chk("kmax_data", out_data, 255);
        finish_handshake("kmax");

        // async reset while presenting a result with ovf set on the narrow lane
        cfg_klen = 8'd2; cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        feed(19'h7FFFF, 19'h7FFFF);
        feed(19'h7FFFF, 19'h7FFFF);
        wait_out("rst_job", lat);
        chk("rst_job_ovf_pre", ovf_n, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_ovf", ovf_n, 0);
        chk("async_rst_out_data", out_data, 0);
        #1 rst_n = 1'b1;
        tick();

        // second cfg_start while busy must not replace klen
        cfg_klen = 8'd2; cfg_start = 1'b1;
        tick();
        cfg_klen = 8'd1;
        tick();
        cfg_start = 1'b0;
        chk("restart_busy", busy, 1);
        feed(19'd0, 19'd1);
        chk("restart_ignored", in_ready, 1);
        feed(19'd0, 19'd2);
        wait_out("restart", lat);
        chk("restart_latency", lat, 2);
        chk("restart_data", out_data, 3);
        finish_handshake("restart");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/npu_cube_acc_seq.md
Name: npu_cube_acc_seq

Overview:
- Sequencer and accumulator behind the last carry-save level of the NPU cube adder tree.
- Accepts one carry/sum pair per beat and resolves it with a carry-propagate add.
- Accumulates a configured number of beats (the K-dimension length), then presents one handshaked result.
- Owns start/abort/busy/done control for one output lane of the cube.

Parameters:
- DWCS, 19, width of the incoming carry and sum vectors.
- DWACC, 32, accumulator and result width; must be at least DWCS+2.
- KCNT_W, 8, width of the beat-count configuration.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- cfg_start  input  1  pulse; latches cfg_klen and starts a job; honoured only in IDLE.
- cfg_klen  input  KCNT_W  number of beats to accumulate; 0 is allowed.
- cfg_abort  input  1  pulse; kills the current job.
- in_valid  input  1  carry/sum beat is valid.
- in_ready  output  1  block accepts a beat.
- in_cay  input  DWCS  carry vector, weight 2 (bit i carries weight 2^(i+1)).
- in_sum  input  DWCS  sum vector, weight 1.
- out_valid  output  1  result is valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  DWACC  accumulated result.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse on the result handshake.
- ovf  output  1  sticky overflow for the current job.

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_data=0, busy=0, done=0, ovf=0. FSM=IDLE; counters, stage-1 register and accumulator all 0.
- FSM states: IDLE, ACC, DRAIN, OUT.
- IDLE, cfg_start=1: latch klen, clear acc, clear ovf, clear beat count.
  - klen!=0: go to ACC.
  - klen=0: go to OUT with out_data=0; no beats are consumed.
- ACC: in_ready=1. A beat is accepted on (in_valid & in_ready).
- Stage 1 (resolve): s1_val <= zero-extend(in_sum) + (zero-extend(in_cay) << 1), width DWCS+2. s1_vld <= accepted.
- Stage 2 (accumulate): when s1_vld, acc <= acc + zero-extend(s1_val) modulo 2^DWACC. If the true sum exceeds 2^DWACC-1, set ovf.
- On the handshake of beat number klen: in_ready drops the next cycle and the FSM goes to DRAIN.
- DRAIN: in_ready=0. Wait one cycle for the last beat to reach acc, then go to OUT.
- Latency: last-beat handshake at edge T gives s1 at T, acc updated at T+1, out_valid high from edge T+2.
- OUT: out_valid=1 and out_data=acc, held stable until out_ready.
  - On (out_valid & out_ready): done=1 for that cycle, then go to IDLE.
  - out_data keeps its last value in IDLE.
- cfg_abort in ACC, DRAIN or OUT: go to IDLE next edge.
  - s1_vld cleared; in_ready and out_valid drop; no done pulse.
  - cfg_abort takes priority over every other event in the same cycle.
- cfg_start outside IDLE: ignored.
- cfg_start and cfg_abort together in IDLE: abort wins, FSM stays IDLE.
- Bubbles (in_valid low) in ACC: no count increment, acc unchanged.
- Beat count wraps safely: klen=2^KCNT_W-1 is the maximum job; the counter never overflows.
- ovf is sticky until the next cfg_start. It is readable during OUT and after return to IDLE.
- Async reset asserted mid-job: all state returns to reset values immediately; any partial accumulation is lost.

Optional Feature:
- Macro: NPU_CUBE_ACC_SAT_EN.
- Defined: when the accumulate overflows, acc clamps to 2^DWACC-1. ovf is set and further beats keep acc clamped.
- Undefined: acc wraps modulo 2^DWACC; ovf is still set.
- Port list is identical in both builds.

Test Plan:
- klen=3; beats (cay,sum)=(1,1),(2,0),(0,5) back-to-back, out_ready=1:
  - out_data=3+4+5=12, out_valid from 2 cycles after the 3rd handshake.
  - done one cycle, in_ready low after the 3rd beat.
- klen=4 with in_valid toggling every other cycle; each beat cay=0x7FFFF, sum=0x7FFFF:
  - each beat resolves to 0x17FFFD; out_data=0x5FFFF4; ovf=0.
- klen=0 with cfg_start:
  - out_valid next cycle, out_data=0, no in_ready pulse.
  - Hold out_ready=0 for 5 cycles: out_data stays 0 and stable.
- DWACC=21, klen=2, beats cay=0x7FFFF, sum=0x7FFFF:
  - SAT_EN build: out_data=0x1FFFFF, ovf=1.
  - Non-SAT build: out_data=(2*0x17FFFD) mod 2^21=0x0FFFFA, ovf=1.
- klen=5, cfg_abort after 2 beats:
  - FSM returns to IDLE, no out_valid, no done.
  - A following job with klen=1 and beat (0,7) gives out_data=7, ovf=0.
- rst_n pulsed low while in OUT:
  - out_valid, busy and ovf go 0 asynchronously.
  - cfg_start while busy, issued after a fresh start, is ignored and the original klen is honoured.
